test_vector_seq: RTL and testbench

TEST_VECTOR_SEQ -- requirements
Module: test_vector_seq

---
 rtl/test_vector_pkg.sv | 34 +++
 rtl/vector_rom.sv | 23 ++
 rtl/test_vector_seq.sv | 187 ++++++++++++++++++
 tb/tb_test_vector_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/test_vector_pkg.sv
// rtl/test_vector_pkg.sv - shared types, FSM states and the constant vector table
package test_vector_pkg;

    // Native width of the stored table; the top resizes to DATA_WIDTH.
    localparam int VEC_DW    = 8;
    localparam int VEC_DEPTH = 8;
    localparam int VEC_IDX_W = 3;

    typedef struct packed {
        logic [VEC_DW-1:0]   inp;
        logic [VEC_DW-1:0]   par;
        logic [2*VEC_DW-1:0] prop;
        logic [2*VEC_DW-1:0] expected;
    } vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

    // expected = inp * par + prop, truncated to 16 bits. Entry 7 is leftmost.
    localparam vec_t [VEC_DEPTH-1:0] VEC_TABLE = {
        vec_t'{8'hAA, 8'h55, 16'h5555, 16'h8DC7},
        vec_t'{8'h0F, 8'hF0, 16'h0000, 16'h0E10},
        vec_t'{8'h80, 8'h02, 16'h1234, 16'h1334},
        vec_t'{8'h10, 8'h10, 16'h0100, 16'h0200},
        vec_t'{8'h01, 8'h01, 16'h0001, 16'h0002},
        vec_t'{8'hFF, 8'hFF, 16'hFFFF, 16'hFE00},
        vec_t'{8'h00, 8'h00, 16'h0000, 16'h0000},
        vec_t'{8'hF1, 8'hC8, 16'h001B, 16'hBC63}
    };

endpackage

// File: rtl/vector_rom.sv
// rtl/vector_rom.sv - combinational lookup of the constant test vector table
// Ports: idx (table index in), vec (vec_t entry out).
// Indices beyond the stored depth alias onto the table modulo VEC_DEPTH.
module vector_rom
    import test_vector_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx,
    output vec_t             vec
);

    logic [VEC_IDX_W-1:0] sel;

    if (IDX_W >= VEC_IDX_W) begin : g_slice
        assign sel = idx[VEC_IDX_W-1:0];
    end else begin : g_extend
        assign sel = VEC_IDX_W'(idx);
    end

    assign vec = VEC_TABLE[sel];

endmodule

// File: rtl/test_vector_seq.sv
// rtl/test_vector_seq.sv - test vector sequencer with optional result checker
// Optional feature macro: VECTOR_CHECK_EN (comparator, counters, timeout, WAIT state).
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   change, auto_en         manual step level (edge-detected), auto-advance enable
//   inp, par, prop, expected current vector from the table
//   vec_valid               one-cycle issue pulse
//   dut_result, res_valid   DUT response and its strobe
//   code                    active-low index display (optionally bit-reversed)
//   pass_cnt, fail_cnt      saturating counters; all_pass, timeout_err status
module test_vector_seq
    import test_vector_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int NUM_VEC     = 8,
    parameter  int AUTO_PERIOD = 50_000_000,
    parameter  int TIMEOUT     = 16,
    parameter  int BIT_REVERSE = 1,
    localparam int IDX_W       = $clog2(NUM_VEC)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    change,
    input  logic                    auto_en,
    output logic [DATA_WIDTH-1:0]   inp,
    output logic [DATA_WIDTH-1:0]   par,
    output logic [2*DATA_WIDTH-1:0] prop,
    output logic [2*DATA_WIDTH-1:0] expected,
    output logic                    vec_valid,
    input  logic [2*DATA_WIDTH-1:0] dut_result,
    input  logic                    res_valid,
    output logic [IDX_W-1:0]        code,
    output logic [15:0]             pass_cnt,
    output logic [15:0]             fail_cnt,
    output logic                    all_pass,
    output logic                    timeout_err
);

    localparam int AUTO_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;

    seq_state_t        state, next_state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_disp;
    logic              change_q;
    logic              change_rise;
    logic              auto_expire;
    logic              advance;
    logic [AUTO_W-1:0] auto_cnt;
    vec_t              rom_vec;

    vector_rom #(.IDX_W(IDX_W)) u_rom (
        .idx (idx),
        .vec (rom_vec)
    );

    if (DATA_WIDTH == VEC_DW) begin : g_native
        assign inp      = rom_vec.inp;
        assign par      = rom_vec.par;
        assign prop     = rom_vec.prop;
        assign expected = rom_vec.expected;
    end else begin : g_resized
        // Stored expected is only valid at the native width; recompute otherwise.
        assign inp      = DATA_WIDTH'(rom_vec.inp);
        assign par      = DATA_WIDTH'(rom_vec.par);
        assign prop     = (2*DATA_WIDTH)'(rom_vec.prop);
        assign expected = (2*DATA_WIDTH)'(inp) * (2*DATA_WIDTH)'(par) + prop;
    end

    for (genvar i = 0; i < IDX_W; i++) begin : g_disp
        assign idx_disp[i] = (BIT_REVERSE != 0) ? idx[IDX_W-1-i] : idx[i];
    end
    assign code = ~idx_disp;

    assign change_rise = change & ~change_q;
    assign auto_expire = auto_en && (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));
    assign vec_valid   = (state == ST_ISSUE);

`ifdef VECTOR_CHECK_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            resp_hit;
    logic            resp_pass;
    logic            timed_out;
`else
    logic            unused_resp;
    assign unused_resp = ^{res_valid, dut_result};
`endif

    always_comb begin
        next_state = state;
`ifdef VECTOR_CHECK_EN
        resp_hit   = 1'b0;
        resp_pass  = 1'b0;
        timed_out  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                // Coincident edge and expiry still produce a single issue.
                if (change_rise || auto_expire) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef VECTOR_CHECK_EN
                next_state = ST_WAIT;
`else
                next_state = ST_IDLE;
`endif
            end
`ifdef VECTOR_CHECK_EN
            ST_WAIT: begin
                if (res_valid) begin
                    resp_hit   = 1'b1;
                    resp_pass  = (dut_result == expected);
                    next_state = ST_IDLE;
                end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef VECTOR_CHECK_EN
    assign advance = (state == ST_WAIT) && (next_state == ST_IDLE);
`else
    assign advance = (state == ST_ISSUE);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            change_q <= 1'b0;
            auto_cnt <= '0;
        end else begin
            state    <= next_state;
            change_q <= change;
            if (advance) begin
                idx <= (idx == IDX_W'(NUM_VEC - 1)) ? '0 : idx + 1'b1;
            end
            // Timer only runs while staying idle in auto mode.
            if ((state == ST_IDLE) && (next_state == ST_IDLE) && auto_en) begin
                auto_cnt <= auto_cnt + 1'b1;
            end else begin
                auto_cnt <= '0;
            end
        end
    end

`ifdef VECTOR_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Counts cycles since the issue cycle, so a timeout lands TIMEOUT edges after it.
            if (state == ST_ISSUE) begin
                wait_cnt <= TO_W'(1);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (resp_hit && resp_pass && (pass_cnt != 16'hFFFF)) begin
                pass_cnt <= pass_cnt + 16'd1;
            end
            if (((resp_hit && !resp_pass) || timed_out) && (fail_cnt != 16'hFFFF)) begin
                fail_cnt <= fail_cnt + 16'd1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign pass_cnt    = '0;
    assign fail_cnt    = '0;
    assign timeout_err = 1'b0;
`endif

    assign all_pass = (pass_cnt != 16'd0) && (fail_cnt == 16'd0);

endmodule

// File: tb/tb_test_vector_seq.sv
// tb/tb_test_vector_seq.sv - self-checking bench for test_vector_seq
module tb_test_vector_seq;

    localparam int DW = 8;
    localparam int NV = 8;
    localparam int AP = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          change = 1'b0;
    logic          auto_en = 1'b0;
    logic          res_valid = 1'b0;
    logic [15:0]   dut_result = '0;
    logic [7:0]    inp, par;
    logic [15:0]   prop, expected;
    logic          vec_valid;
    logic [2:0]    code;
    logic [15:0]   pass_cnt, fail_cnt;
    logic          all_pass, timeout_err;

    always #5 clk = ~clk;

    test_vector_seq #(
        .DATA_WIDTH (DW),
        .NUM_VEC    (NV),
        .AUTO_PERIOD(AP),
        .TIMEOUT    (TO),
        .BIT_REVERSE(1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .change     (change),
        .auto_en    (auto_en),
        .inp        (inp),
        .par        (par),
        .prop       (prop),
        .expected   (expected),
        .vec_valid  (vec_valid),
        .dut_result (dut_result),
        .res_valid  (res_valid),
        .code       (code),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .all_pass   (all_pass),
        .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_idx  = 0;
    int m_pass = 0;
    int m_fail = 0;
    int m_tmo  = 0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_result(logic [7:0] a, logic [7:0] b, logic [15:0] p);
        int unsigned r;
        r = int'(a) * int'(b) + int'(p);
        return r[15:0];
    endfunction

    function automatic logic [2:0] ref_code(int idx);
        int r = 0;
        for (int i = 0; i < 3; i++) begin
            if (((idx >> i) & 1) != 0) r = r | (1 << (2 - i));
        end
        return 3'(7 - r);
    endfunction

    task automatic check_state(string tag);
        chk({tag, ".code"},     code,        ref_code(m_idx));
        chk({tag, ".pass"},     pass_cnt,    m_pass);
        chk({tag, ".fail"},     fail_cnt,    m_fail);
        chk({tag, ".allpass"},  all_pass,    (m_pass > 0 && m_fail == 0) ? 1 : 0);
        chk({tag, ".timeout"},  timeout_err, m_tmo);
        chk({tag, ".table"},    expected,    ref_result(inp, par, prop));
    endtask

    task automatic model_reset();
        m_idx  = 0;
        m_pass = 0;
        m_fail = 0;
        m_tmo  = 0;
    endtask

`ifdef VECTOR_CHECK_EN
    // kind: 0 = correct response, 1 = wrong response, 2 = no response (timeout)
    task automatic manual_step(string tag, int kind, int lat, bit glitch);
        logic [7:0]  a, b;
        logic [15:0] p, want;
        // res_valid in IDLE must not be counted
        res_valid  = 1'b1;
        dut_result = 16'($urandom);
        step();
        res_valid = 1'b0;
        change    = 1'b1;
        step();
        chk({tag, ".issue"}, vec_valid, 1);
        change = 1'b0;
        a = inp; b = par; p = prop;
        want = ref_result(a, b, p);
        chk({tag, ".exp"}, expected, want);
        step();
        chk({tag, ".pulse"}, vec_valid, 0);
        if (glitch) change = 1'b1;
        if (kind == 2) begin
            repeat (TO - 2) step();
            chk({tag, ".early"}, fail_cnt, m_fail);
            chk({tag, ".stable"}, {inp, par, prop}, {a, b, p});
            step();
            m_fail++;
            m_tmo = 1;
        end else begin
            repeat (lat) step();
            chk({tag, ".stable"}, {inp, par, prop}, {a, b, p});
            res_valid  = 1'b1;
            dut_result = (kind == 0) ? want : (want ^ (16'h1 << $urandom_range(0, 15)));
            step();
            res_valid = 1'b0;
            if (kind == 0) m_pass++;
            else m_fail++;
        end
        m_idx = (m_idx + 1) % NV;
        check_state(tag);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, ".noqueue"}, vec_valid, 0);
        end
        change = 1'b0;
        step();
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        repeat (3) step();
        model_reset();
        check_state("reset");
        chk("reset.vec_valid", vec_valid, 0);
        chk("reset.entry0", {inp, par, prop, expected}, {8'hF1, 8'hC8, 16'h001B, 16'hBC63});
        reset_n = 1'b1;
        step();

`ifdef VECTOR_CHECK_EN
        manual_step("first_pass", 0, 1, 1'b0);
        chk("first_pass.code011", code, 3'b011);
        manual_step("wrong_resp", 1, 0, 1'b0);
        chk("wrong_resp.allpass", all_pass, 0);
        manual_step("timeout", 2, 0, 1'b1);
        for (int n = 0; n < 10; n++) begin
            manual_step("random", $urandom_range(0, 2), $urandom_range(0, TO - 3), 1'($urandom_range(0, 1)));
        end

        // Change edge during WAIT, then reset mid-WAIT
        change = 1'b1;
        step();
        chk("rstwait.issue", vec_valid, 1);
        change = 1'b0;
        step();
        change = 1'b1;
        step();
        reset_n = 1'b0;
        step();
        model_reset();
        check_state("rstwait");
        chk("rstwait.vec_valid", vec_valid, 0);
        change = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstwait.noissue", vec_valid, 0);
        end

        // Auto mode with an ideal responder over two full table passes
        auto_en = 1'b1;
        for (int n = 0; n < 2 * NV; n++) begin
            int k;
            logic [15:0] want;
            k = 0;
            while (vec_valid !== 1'b1 && k < 20) begin
                step();
                k++;
            end
            chk("auto.issue", vec_valid, 1);
            if (n > 0) chk("auto.period", k, AP);
            want = ref_result(inp, par, prop);
            step();
            repeat ($urandom_range(0, 3)) step();
            res_valid  = 1'b1;
            dut_result = want;
            step();
            res_valid = 1'b0;
            m_pass++;
            m_idx = (m_idx + 1) % NV;
            check_state("auto");
        end
        auto_en = 1'b0;
        chk("auto.pass16", pass_cnt, 16);
        chk("auto.wrap", code, ref_code(0));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("auto.off", vec_valid, 0);
        end
`else
        // Checker absent: responses ignored, each edge issues and advances
        for (int n = 0; n < 3; n++) begin
            res_valid  = 1'b1;
            dut_result = 16'($urandom);
            change     = 1'b1;
            step();
            chk("nochk.issue", vec_valid, 1);
            chk("nochk.code_hold", code, ref_code(m_idx));
            change = 1'b0;
            step();
            chk("nochk.pulse", vec_valid, 0);
            m_idx = (m_idx + 1) % NV;
            check_state("nochk");
            repeat ($urandom_range(0, 3)) step();
        end
        res_valid = 1'b0;
        chk("nochk.idx3", code, ref_code(3));
        chk("nochk.pass0", pass_cnt, 0);
        chk("nochk.fail0", fail_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
